// File: rtl/pipelined_adder_seg_if.sv
// Operand/result handshake bundle for pipelined_adder_seg.
// ADDER_OVF_EN adds the registered signed-overflow flag to the result side.
interface pipelined_adder_seg_if #(
    parameter int unsigned N = 24
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] input1;
    logic [N-1:0] input2;
    logic         carry_in;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] answer;
    logic         carry_out;
`ifdef ADDER_OVF_EN
    logic         overflow;
`endif

    modport slave (
        input  in_valid, input1, input2, carry_in, sub, out_ready,
`ifdef ADDER_OVF_EN
        output overflow,
`endif
        output in_ready, out_valid, answer, carry_out
    );

    modport master (
        output in_valid, input1, input2, carry_in, sub, out_ready,
`ifdef ADDER_OVF_EN
        input  overflow,
`endif
        input  in_ready, out_valid, answer, carry_out
    );
endinterface

// File: rtl/pipelined_adder_seg.sv
// Segmented pipelined adder/subtractor: one SEG-bit carry segment per stage, STAGES = N/SEG.
// Optional `define ADDER_OVF_EN exposes a registered two's-complement overflow flag.
module pipelined_adder_seg #(
    parameter int unsigned N   = 24,
    parameter int unsigned SEG = 6
) (
    input logic                  clk,
    input logic                  rst_n,
    pipelined_adder_seg_if.slave bus
);
    localparam int unsigned STAGES = N / SEG;
    localparam int unsigned LAST   = STAGES - 1;

    logic         r_vld   [STAGES];
    logic         r_carry [STAGES];
    logic [N-1:0] r_sum   [STAGES];
    logic [N-1:0] r_a     [STAGES];
    logic [N-1:0] r_b     [STAGES];

    logic         w_en;
    logic         w_v_in  [STAGES];
    logic         w_c_in  [STAGES];
    logic [N-1:0] w_a_in  [STAGES];
    logic [N-1:0] w_b_in  [STAGES];
    logic [N-1:0] w_s_in  [STAGES];
    logic [N-1:0] w_s_nx  [STAGES];
    logic [SEG:0] w_seg   [STAGES];

    assign w_en          = !r_vld[LAST] || bus.out_ready;
    assign bus.in_ready  = w_en;
    assign bus.out_valid = r_vld[LAST];
    assign bus.answer    = r_sum[LAST];
    assign bus.carry_out = r_carry[LAST];

    // Stage k sees either the conditioned inputs (k=0) or stage k-1's registers.
    always_comb begin
        w_v_in[0] = bus.in_valid;
        w_a_in[0] = bus.input1;
        w_b_in[0] = bus.input2 ^ {N{bus.sub}};
        w_c_in[0] = bus.carry_in ^ bus.sub;
        w_s_in[0] = '0;
        for (int unsigned k = 1; k < STAGES; k++) begin
            w_v_in[k] = r_vld[k-1];
            w_a_in[k] = r_a[k-1];
            w_b_in[k] = r_b[k-1];
            w_c_in[k] = r_carry[k-1];
            w_s_in[k] = r_sum[k-1];
        end
        for (int unsigned k = 0; k < STAGES; k++) begin
            w_seg[k]  = {1'b0, w_a_in[k][k*SEG +: SEG]}
                      + {1'b0, w_b_in[k][k*SEG +: SEG]}
                      + {{SEG{1'b0}}, w_c_in[k]};
            w_s_nx[k] = w_s_in[k];
            w_s_nx[k][k*SEG +: SEG] = w_seg[k][SEG-1:0];
        end
    end

    // Data registers load only with a valid beat so the output holds its last result through bubbles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                r_vld[k]   <= 1'b0;
                r_carry[k] <= 1'b0;
                r_sum[k]   <= '0;
                r_a[k]     <= '0;
                r_b[k]     <= '0;
            end
        end else if (w_en) begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                r_vld[k] <= w_v_in[k];
                if (w_v_in[k]) begin
                    r_carry[k] <= w_seg[k][SEG];
                    r_sum[k]   <= w_s_nx[k];
                    r_a[k]     <= w_a_in[k];
                    r_b[k]     <= w_b_in[k];
                end
            end
        end
    end

`ifdef ADDER_OVF_EN
    logic r_ovf;
    logic w_ovf_nx;

    // Carry into the MSB is recovered from the MSB sum bit and its operand bits.
    always_comb begin
        w_ovf_nx = w_a_in[LAST][N-1] ^ w_b_in[LAST][N-1] ^ w_seg[LAST][SEG-1] ^ w_seg[LAST][SEG];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if (w_en && w_v_in[LAST]) begin
            r_ovf <= w_ovf_nx;
        end
    end

    assign bus.overflow = r_ovf;
`endif

endmodule
